// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, majority-vote bit decisions,
// a dataAvailable/dataTaken handshake and sticky framing/overrun flags.
module uart_rx (
  input  logic       clk,
  input  logic       reset,
  input  logic       sampleEn,
  input  logic       uartInput,
  input  logic       dataTaken,
  input  logic       clearErrors,
  output logic [7:0] data,
  output logic       dataAvailable,
  output logic       framingError,
  output logic       overrun
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t      state, state_next;
  logic        sync1, rxSync;
  logic [3:0]  phase, phase_next, tick_phase;
  logic [2:0]  bitCount, bitCount_next;
  logic [7:0]  shreg, shreg_next;
  logic [1:0]  samples;
  logic        decide, bit_val, deliver, frame_err, accept;

  // The detection tick is phase 0; every later sampleEn is numbered by tick_phase.
  assign tick_phase = phase + 4'd1;
  assign decide     = sampleEn && (tick_phase == 4'd9);
  // Phase-7 and phase-8 samples are held; the phase-9 sample is rxSync itself.
  assign bit_val    = (samples[1] & samples[0]) | (samples[1] & rxSync) |
                      (samples[0] & rxSync);
  assign accept     = deliver && (!dataAvailable || dataTaken);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; combinational next-state logic stays in always_comb.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1         <= 1'b1;
      rxSync        <= 1'b1;
      state         <= IDLE;
      phase         <= 4'd0;
      bitCount      <= 3'd0;
      shreg         <= 8'h00;
      samples       <= 2'b11;
      data          <= 8'h00;
      dataAvailable <= 1'b0;
      framingError  <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      sync1    <= uartInput;
      rxSync   <= sync1;
      state    <= state_next;
      phase    <= phase_next;
      bitCount <= bitCount_next;
      shreg    <= shreg_next;
      if (sampleEn && (tick_phase == 4'd7 || tick_phase == 4'd8))
        samples <= {samples[0], rxSync};
      if (accept) begin
        data          <= shreg;
        dataAvailable <= 1'b1;
      end else if (dataTaken) begin
        dataAvailable <= 1'b0;
      end
      // Set has priority over a coincident clear.
      framingError <= frame_err | (framingError & ~clearErrors);
      overrun      <= (deliver & ~accept) | (overrun & ~clearErrors);
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next    = state;
    phase_next    = sampleEn ? tick_phase : phase;
    bitCount_next = bitCount;
    shreg_next    = shreg;
    deliver       = 1'b0;
    frame_err     = 1'b0;
    case (state)
      IDLE:
        if (sampleEn && !rxSync) begin
          state_next = START;
          phase_next = 4'd0;
        end
      START:
        if (decide) begin
          if (bit_val) begin
            state_next = IDLE;
          end else begin
            state_next    = DATA;
            bitCount_next = 3'd0;
          end
        end
      DATA:
        if (decide) begin
          shreg_next = {bit_val, shreg[7:1]};
          if (bitCount == 3'd7) state_next = STOP;
          else                  bitCount_next = bitCount + 3'd1;
        end
      STOP:
        if (decide) begin
          if (bit_val) begin
            state_next = IDLE;
            deliver    = 1'b1;
          end else begin
            state_next = BREAK;
            frame_err  = 1'b1;
          end
        end
      BREAK:
        if (sampleEn && rxSync) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are built tick-by-tick (16 sampleEn per
// bit), expected bytes are queued by a reference decoder and checked by a monitor.
module tb_uart_rx;

  logic       clk, reset, sampleEn, uartInput, dataTaken, clearErrors;
  logic [7:0] data;
  logic       dataAvailable, framingError, overrun;

  uart_rx dut (
    .clk(clk), .reset(reset), .sampleEn(sampleEn), .uartInput(uartInput),
    .dataTaken(dataTaken), .clearErrors(clearErrors), .data(data),
    .dataAvailable(dataAvailable), .framingError(framingError), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];
  logic       auto_take = 1'b0;
  logic       prev_avail = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Frame as seen on the line, one bit per sampleEn tick: start, LSB-first data, stop.
  function automatic logic [159:0] make_frame(input logic [7:0] b, input logic stop);
    logic [9:0]   bits;
    logic [159:0] f;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 160; i++) f[i] = bits[i/16];
    return f;
  endfunction

  // Reference decoder: each bit is the 2-of-3 vote of ticks 7, 8, 9 within the bit.
  function automatic logic [8:0] decode(input logic [159:0] f);
    logic [9:0] bits;
    for (int k = 0; k < 10; k++)
      bits[k] = (int'(f[16*k+7]) + int'(f[16*k+8]) + int'(f[16*k+9])) >= 2;
    return {bits[9], bits[8:1]};
  endfunction

  // One sampleEn period of 4 clk; called and returns at a negedge.
  task automatic do_tick(input logic v, input logic take);
    uartInput = v;
    if (auto_take && dataAvailable) begin
      dataTaken = 1'b1;
      @(negedge clk);
      dataTaken = 1'b0;
      repeat (2) @(negedge clk);
    end else begin
      repeat (3) @(negedge clk);
    end
    sampleEn  = 1'b1;
    dataTaken = take;
    @(negedge clk);
    sampleEn  = 1'b0;
    dataTaken = 1'b0;
  endtask

  task automatic send_frame(input logic [159:0] f, input int take_at);
    for (int i = 0; i < 160; i++) do_tick(f[i], i == take_at);
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick(1'b1, 1'b0);
  endtask

  task automatic pulse(input int which);
    if (which == 0) dataTaken = 1'b1; else clearErrors = 1'b1;
    @(negedge clk);
    dataTaken   = 1'b0;
    clearErrors = 1'b0;
  endtask

  // Monitor: a delivery is a rising dataAvailable or a new byte while it stays high.
  always @(negedge clk) begin
    if (!reset && dataAvailable && (!prev_avail || data != prev_data)) begin
      if (exp_q.size() == 0) check("delivery_expected", 32'(exp_q.size() != 0), 1);
      else                   check("rx_byte", data, exp_q.pop_front());
    end
    prev_avail = dataAvailable;
    prev_data  = data;
  end

  initial begin
    logic [159:0] f;
    logic [8:0]   d;
    reset = 1'b1; sampleEn = 1'b0; uartInput = 1'b1; dataTaken = 1'b0; clearErrors = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {data, dataAvailable, framingError, overrun}, 0);
    reset = 1'b0;

    // Idle line for 1000 clk: nothing may change.
    for (int i = 0; i < 10; i++) begin
      idle_ticks(25);
      check("idle_outputs", {data, dataAvailable, framingError, overrun}, 0);
    end

    // Single byte, delivery exactly on the stop-decision tick (tick 153).
    f = make_frame(8'hA5, 1'b1);
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 160; i++) begin
      do_tick(f[i], 1'b0);
      if (i == 152) check("a5_not_early", dataAvailable, 0);
      if (i == 153) check("a5_on_stop_edge", {dataAvailable, data}, {1'b1, 8'hA5});
    end
    pulse(0);
    check("a5_taken_clears", dataAvailable, 0);
    check("a5_no_flags", {framingError, overrun}, 0);

    // Short low glitch on an idle line.
    for (int i = 0; i < 4; i++) do_tick(1'b0, 1'b0);
    idle_ticks(28);
    check("glitch_no_output", {dataAvailable, framingError, overrun}, 0);

    // Phase-8 sample inverted in every bit; the vote must still recover 0x3C.
    auto_take = 1'b1;
    f = make_frame(8'h3C, 1'b1);
    for (int k = 0; k < 10; k++) f[16*k+8] = ~f[16*k+8];
    exp_q.push_back(8'h3C);
    send_frame(f, -1);
    idle_ticks(4);
    check("maj_no_flags", {framingError, overrun}, 0);

    // Framing error then a held-low line (break), then a good frame.
    send_frame(make_frame(8'h55, 1'b0), -1);
    for (int i = 0; i < 480; i++) do_tick(1'b0, 1'b0);
    idle_ticks(16);
    check("break_flags", {dataAvailable, framingError}, 2'b01);
    exp_q.push_back(8'h12);
    send_frame(make_frame(8'h12, 1'b1), -1);
    idle_ticks(4);
    check("fe_sticky", framingError, 1);
    pulse(1);
    check("fe_cleared", framingError, 0);

    // Overrun: second byte discarded while the first is unread.
    auto_take = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(make_frame(8'h11, 1'b1), -1);
    send_frame(make_frame(8'h22, 1'b1), -1);
    check("overrun_kept", {dataAvailable, overrun, data}, {2'b11, 8'h11});
    pulse(1);
    pulse(0);
    check("overrun_cleared", {dataAvailable, overrun}, 0);
    // Same again, with dataTaken on the second stop-decision edge.
    exp_q.push_back(8'h11);
    send_frame(make_frame(8'h11, 1'b1), -1);
    exp_q.push_back(8'h22);
    send_frame(make_frame(8'h22, 1'b1), 153);
    check("take_same_edge", {dataAvailable, overrun, data}, {2'b10, 8'h22});

    // Asynchronous reset during data bit 4 of 0xF0.
    f = make_frame(8'hF0, 1'b1);
    for (int i = 0; i < 84; i++) do_tick(f[i], 1'b0);
    #2 reset = 1'b1;
    #1 check("reset_immediate", {data, dataAvailable, framingError, overrun}, 0);
    uartInput = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    idle_ticks(4);
    exp_q.push_back(8'h0F);
    send_frame(make_frame(8'h0F, 1'b1), -1);
    pulse(0);

    // Randomized frames with off-centre noise, random gaps including back-to-back.
    auto_take = 1'b1;
    for (int n = 0; n < 24; n++) begin
      f = make_frame(8'($urandom_range(0, 255)), 1'b1);
      for (int k = 1; k < 9; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          int j;
          j = 16*k + 7 + int'($urandom_range(0, 2));
          f[j] = ~f[j];
        end
        if ($urandom_range(0, 1) == 1) begin
          int j;
          j = 16*k + (($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 6))
                                                   : int'($urandom_range(10, 15)));
          f[j] = ~f[j];
        end
      end
      d = decode(f);
      exp_q.push_back(d[7:0]);
      send_frame(f, -1);
      idle_ticks(int'($urandom_range(0, 3)));
    end
    idle_ticks(4);
    check("random_no_flags", {framingError, overrun}, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
